// File: rtl/wb_pkg.sv
// Shared write-back stage definitions: widths, WB control bit positions,
// and the hardwired-zero register index.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 1 << ADDR_W;

  // Bit positions inside the 2-bit WB control bundle from MEM/WB
  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

  function automatic logic is_zero_reg(
    input logic [ADDR_W-1:0] idx
  );
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_reg_array.sv
// Architectural register storage: NREGS x DATA_W, one synchronous
// write port with synchronous clear, two asynchronous read ports.
// Ports:
//   clk        rising-edge clock
//   clr        sync clear of every register (wins over we)
//   we         write enable; writes to r0 are dropped here too
//   waddr      write index
//   wdata      write value
//   raddr1/2   read indices
//   rdata1/2   stored values (r0 always reads 0)
module wb_reg_array
  import wb_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W,
  parameter int NR = NREGS
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] regs_q [NR];
  logic [DW-1:0] regs_d [NR];

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (clr) begin
      for (int i = 0; i < NR; i++) begin
        regs_d[i] = '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // r0 is never written, but force the read to 0 so its
  // pre-reset contents can never leak out.
  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
  end

endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage: selects the WB value, commits it to the register file,
// serves two ID read ports with write-through bypass, counts commits.
// Ports:
//   clk, rst                 clock, sync active-high reset
//   WBIn                     {RegWrite, MemToReg} from MEM/WB
//   MemReadDataIn            load data from MEM/WB
//   ALUResultIn              ALU result from MEM/WB
//   RegDstIn                 destination register from MEM/WB
//   ReadReg1/2, ReadData1/2  ID read ports (combinational, bypassed)
//   WriteDataOut             selected write-back value
//   WriteRegOut              destination register (pass-through)
//   RegWriteOut              qualified write enable
//   WriteCount               registered count of committed writes
module wb_regfile_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int NREGS  = wb_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        WBIn,
  input  logic [DATA_W-1:0] MemReadDataIn,
  input  logic [DATA_W-1:0] ALUResultIn,
  input  logic [ADDR_W-1:0] RegDstIn,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteDataOut,
  output logic [ADDR_W-1:0] WriteRegOut,
  output logic              RegWriteOut,
  output logic [31:0]       WriteCount
);

  logic              reg_write;
  wb_src_e           wb_src;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [DATA_W-1:0] arr_rd1;
  logic [DATA_W-1:0] arr_rd2;
  logic [31:0]       wcount_q;
  logic [31:0]       wcount_d;

  assign reg_write = WBIn[WB_REGWRITE_BIT];
  assign wb_src    = wb_src_e'(WBIn[WB_MEMTOREG_BIT]);

  always_comb begin
    wr_data = ALUResultIn;
    if (wb_src == WB_SRC_MEM) begin
      wr_data = MemReadDataIn;
    end
  end

  // Reset masks the enable so the write is dropped, the
  // bypass is off and the forwarding unit sees no write.
  always_comb begin
    wr_en = reg_write
          & ~is_zero_reg(RegDstIn)
          & ~rst;
  end

  wb_reg_array #(
    .DW (DATA_W),
    .AW (ADDR_W),
    .NR (NREGS)
  ) u_array (
    .clk    (clk),
    .clr    (rst),
    .we     (wr_en),
    .waddr  (RegDstIn),
    .wdata  (wr_data),
    .raddr1 (ReadReg1),
    .raddr2 (ReadReg2),
    .rdata1 (arr_rd1),
    .rdata2 (arr_rd2)
  );

  // wr_en already excludes r0, so a bypass hit can never
  // return non-zero for a read of r0.
  always_comb begin
    ReadData1 = arr_rd1;
    ReadData2 = arr_rd2;
    if (wr_en && (ReadReg1 == RegDstIn)) begin
      ReadData1 = wr_data;
    end
    if (wr_en && (ReadReg2 == RegDstIn)) begin
      ReadData2 = wr_data;
    end
  end

  always_comb begin
    wcount_d = wcount_q;
    if (rst) begin
      wcount_d = '0;
    end else if (wr_en) begin
      wcount_d = wcount_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    wcount_q <= wcount_d;
  end

  assign WriteDataOut = wr_data;
  assign WriteRegOut  = RegDstIn;
  assign RegWriteOut  = wr_en;
  assign WriteCount   = wcount_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Scoreboard bench for wb_regfile_stage: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_wb_regfile_stage;

  localparam int SEL_RD1 = 0;
  localparam int SEL_RD2 = 1;
  localparam int SEL_WD  = 2;
  localparam int SEL_WR  = 3;
  localparam int SEL_RWE = 4;
  localparam int SEL_CNT = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  WBIn;
  logic [31:0] MemReadDataIn;
  logic [31:0] ALUResultIn;
  logic [4:0]  RegDstIn;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WriteDataOut;
  logic [4:0]  WriteRegOut;
  logic        RegWriteOut;
  logic [31:0] WriteCount;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  always #5 clk = ~clk;

  wb_regfile_stage dut (
    .clk           (clk),
    .rst           (rst),
    .WBIn          (WBIn),
    .MemReadDataIn (MemReadDataIn),
    .ALUResultIn   (ALUResultIn),
    .RegDstIn      (RegDstIn),
    .ReadReg1      (ReadReg1),
    .ReadReg2      (ReadReg2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .WriteDataOut  (WriteDataOut),
    .WriteRegOut   (WriteRegOut),
    .RegWriteOut   (RegWriteOut),
    .WriteCount    (WriteCount)
  );

  task automatic expect_v(input string nm, input int sel,
                          input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are settled mid-cycle, compare every queued item
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        SEL_RD1: act = ReadData1;
        SEL_RD2: act = ReadData2;
        SEL_WD:  act = WriteDataOut;
        SEL_WR:  act = {27'd0, WriteRegOut};
        SEL_RWE: act = {31'd0, RegWriteOut};
        default: act = WriteCount;
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    repeat (2000) @(posedge clk);
    if (!done) begin
      $display("FAIL watchdog: got timeout want done");
      $fatal(1, "timeout");
    end
  end

  initial begin
    rst = 1'b1;
    WBIn = 2'b00;
    MemReadDataIn = '0;
    ALUResultIn = '0;
    RegDstIn = '0;
    ReadReg1 = '0;
    ReadReg2 = '0;
    step();

    // 1: reset cycle with a write presented -> enable masked
    WBIn = 2'b10; RegDstIn = 5'd4; ALUResultIn = 32'h77;
    expect_v("rst_rwe", SEL_RWE, 32'd0);
    expect_v("rst_wreg", SEL_WR, 32'd4);
    expect_v("rst_wdata", SEL_WD, 32'h77);
    step();
    rst = 1'b0; WBIn = 2'b00;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(31 - i);
      expect_v("rst_rd1", SEL_RD1, 32'd0);
      expect_v("rst_rd2", SEL_RD2, 32'd0);
      if (i == 0) expect_v("rst_cnt", SEL_CNT, 32'd0);
      step();
    end

    // 2: ALU write with same-cycle bypass
    WBIn = 2'b10; ALUResultIn = 32'h1234_5678; RegDstIn = 5'd5;
    ReadReg1 = 5'd5; ReadReg2 = 5'd6;
    expect_v("alu_byp", SEL_RD1, 32'h1234_5678);
    expect_v("alu_wd", SEL_WD, 32'h1234_5678);
    expect_v("alu_rwe", SEL_RWE, 32'd1);
    expect_v("alu_rd2", SEL_RD2, 32'd0);
    expect_v("alu_cnt0", SEL_CNT, 32'd0);
    step();
    WBIn = 2'b00;
    expect_v("alu_arr", SEL_RD1, 32'h1234_5678);
    expect_v("alu_cnt1", SEL_CNT, 32'd1);
    step();

    // 3: load write selects memory data
    WBIn = 2'b11; MemReadDataIn = 32'hDEAD_BEEF;
    ALUResultIn = 32'h0; RegDstIn = 5'd31;
    expect_v("ld_wd", SEL_WD, 32'hDEAD_BEEF);
    step();
    WBIn = 2'b00; ALUResultIn = 32'h55; ReadReg2 = 5'd31;
    expect_v("ld_arr", SEL_RD2, 32'hDEAD_BEEF);
    expect_v("ld_cnt", SEL_CNT, 32'd2);
    step();

    // 4: r0 guard
    WBIn = 2'b10; RegDstIn = 5'd0; ALUResultIn = 32'hFFFF_FFFF;
    ReadReg1 = 5'd0;
    expect_v("r0_rwe", SEL_RWE, 32'd0);
    expect_v("r0_byp", SEL_RD1, 32'd0);
    expect_v("r0_wd", SEL_WD, 32'hFFFF_FFFF);
    step();
    WBIn = 2'b00;
    expect_v("r0_rd", SEL_RD1, 32'd0);
    expect_v("r0_cnt", SEL_CNT, 32'd2);
    step();

    // 5: dual bypass, then disabled write leaves r7 alone
    ReadReg1 = 5'd7; ReadReg2 = 5'd7;
    WBIn = 2'b10; RegDstIn = 5'd7; ALUResultIn = 32'hA5A5_A5A5;
    expect_v("dual_rd1", SEL_RD1, 32'hA5A5_A5A5);
    expect_v("dual_rd2", SEL_RD2, 32'hA5A5_A5A5);
    step();
    WBIn = 2'b00; ALUResultIn = 32'h0001_2345;
    expect_v("dis_rwe", SEL_RWE, 32'd0);
    expect_v("dis_rd1", SEL_RD1, 32'hA5A5_A5A5);
    expect_v("dis_rd2", SEL_RD2, 32'hA5A5_A5A5);
    expect_v("dis_cnt", SEL_CNT, 32'd3);
    step();
    expect_v("dis_rd1b", SEL_RD1, 32'hA5A5_A5A5);
    expect_v("dis_cntb", SEL_CNT, 32'd3);
    step();

    // 6: reset mid-write
    WBIn = 2'b10; RegDstIn = 5'd3; ALUResultIn = 32'h11;
    ReadReg1 = 5'd3;
    step();
    rst = 1'b1; ALUResultIn = 32'h22;
    expect_v("mrst_rwe", SEL_RWE, 32'd0);
    expect_v("mrst_nobyp", SEL_RD1, 32'h11);
    expect_v("mrst_wd", SEL_WD, 32'h22);
    expect_v("mrst_cnt4", SEL_CNT, 32'd4);
    step();
    rst = 1'b0; WBIn = 2'b00;
    expect_v("mrst_r3", SEL_RD1, 32'd0);
    expect_v("mrst_cnt", SEL_CNT, 32'd0);
    step();

    // wrap: deposit an all-ones count, then one write
    WBIn = 2'b10; RegDstIn = 5'd9; ALUResultIn = 32'h99;
    dut.wcount_q = 32'hFFFF_FFFF;
    #1;
    expect_v("wrap_pre", SEL_CNT, 32'hFFFF_FFFF);
    step();
    WBIn = 2'b00; ReadReg1 = 5'd9;
    expect_v("wrap_cnt", SEL_CNT, 32'd0);
    expect_v("wrap_r9", SEL_RD1, 32'h99);
    step();

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d left want 0", sb_q.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
